// File: rtl/mem_arbiter_if.sv
// Request/acknowledge bundle for both requester ports plus the memory-side strobes.
// slave = arbiter view; master = requesters and memory view.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_wd;
  logic [DW-1:0] cpu_rd;
  logic          cpu_ack;
  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_adr;
  logic [DW-1:0] dma_wd;
  logic [DW-1:0] dma_rd;
  logic          dma_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;
  logic          busy;
  logic          owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_wd,
    output cpu_rd, cpu_ack,
    input  dma_req, dma_we, dma_adr, dma_wd,
    output dma_rd, dma_ack,
    output mem_en, mem_we, mem_adr, mem_wd,
    input  mem_rd,
    output busy, owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_wd,
    input  cpu_rd, cpu_ack,
    output dma_req, dma_we, dma_adr, dma_wd,
    input  dma_rd, dma_ack,
    input  mem_en, mem_we, mem_adr, mem_wd,
    output mem_rd,
    input  busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// CPU/DMA sharing of one fixed-latency memory, CPU priority with a DMA starvation guard.
// Write acks 2 cycles after the IDLE grant, reads 2+LAT; losing requester simply stays pending.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LAT     = 2,
  parameter int MAXWAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int SW = $clog2(MAXWAIT + 1);
  localparam logic [CW-1:0] CNT_LOAD   = CW'(LAT - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAXWAIT);

  logic [1:0]    state_q,  state_d;
  logic          owner_q,  owner_d;
  logic          we_q,     we_d;
  logic [AW-1:0] adr_q,    adr_d;
  logic [DW-1:0] wd_q,     wd_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [DW-1:0] rdata_q,  rdata_d;
  logic          grant_dma;

  // DMA wins a tie only once the CPU has used up its streak allowance.
  assign grant_dma = bus.dma_req && (!bus.cpu_req || (streak_q == STREAK_MAX));

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    adr_d    = adr_q;
    wd_d     = wd_q;
    streak_d = streak_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req || bus.dma_req) begin
          state_d = S_ISSUE;
          owner_d = grant_dma;
          if (grant_dma) begin
            we_d     = bus.dma_we;
            adr_d    = bus.dma_adr;
            wd_d     = bus.dma_wd;
            streak_d = '0;
          end else begin
            we_d  = bus.cpu_we;
            adr_d = bus.cpu_adr;
            wd_d  = bus.cpu_wd;
            if (!bus.dma_req)
              streak_d = '0;
            else if (streak_q != STREAK_MAX)
              streak_d = streak_q + 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = bus.mem_rd;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      wd_q     <= '0;
      streak_q <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      wd_q     <= wd_d;
      streak_q <= streak_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
    end
  end

  // Strobes decode straight from state so an async reset kills them in the same cycle.
  assign bus.mem_en  = (state_q == S_ISSUE);
  assign bus.mem_we  = (state_q == S_ISSUE) && we_q;
  assign bus.mem_adr = adr_q;
  assign bus.mem_wd  = wd_q;
  assign bus.cpu_ack = (state_q == S_DONE) && !owner_q;
  assign bus.dma_ack = (state_q == S_DONE) && owner_q;
  assign bus.cpu_rd  = rdata_q;
  assign bus.dma_rd  = rdata_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.owner   = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: dut_a built with LAT=2, dut_b with LAT=1, each with its own memory model.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_init = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(32), .DW(32)) ifa ();
  mem_arbiter_if #(.AW(32), .DW(32)) ifb ();

  mem_arbiter #(.AW(32), .DW(32), .LAT(2), .MAXWAIT(4)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  mem_arbiter #(.AW(32), .DW(32), .LAT(1), .MAXWAIT(4)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  // Memory models: read data is only valid exactly LAT cycles after the issue cycle.
  logic [31:0] tmem_a [0:63];
  logic [31:0] tmem_b [0:63];
  logic        pa0_v, pa1_v, pb0_v;
  logic [31:0] pa0_d, pa1_d, pb0_d;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) begin
        tmem_a[i] <= 32'h1000_0000 + i;
        tmem_b[i] <= 32'h2000_0000 + i;
      end
      tmem_a[4] <= 32'hDEAD_BEEF;
      tmem_b[4] <= 32'hCAFE_F00D;
    end else begin
      if (ifa.mem_en && ifa.mem_we) tmem_a[ifa.mem_adr[7:2]] <= ifa.mem_wd;
      if (ifb.mem_en && ifb.mem_we) tmem_b[ifb.mem_adr[7:2]] <= ifb.mem_wd;
    end
    pa0_v <= ifa.mem_en && !ifa.mem_we;
    pa0_d <= tmem_a[ifa.mem_adr[7:2]];
    pa1_v <= pa0_v;
    pa1_d <= pa0_d;
    pb0_v <= ifb.mem_en && !ifb.mem_we;
    pb0_d <= tmem_b[ifb.mem_adr[7:2]];
  end

  assign ifa.mem_rd = pa1_v ? pa1_d : 32'hBAD0_BAD0;
  assign ifb.mem_rd = pb0_v ? pb0_d : 32'hBAD0_BAD0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Steps until the selected ack pulses; cyc=-1 when the budget expires.
  task automatic wait_ack(input bit use_b, input bit dma, input int budget, output int cyc);
    logic a;
    cyc = -1;
    for (int k = 1; k <= budget; k++) begin
      step();
      if (use_b) a = dma ? ifb.dma_ack : ifb.cpu_ack;
      else       a = dma ? ifa.dma_ack : ifa.cpu_ack;
      if (a === 1'b1) begin
        cyc = k;
        break;
      end
    end
  endtask

  initial begin
    int cyc, ccyc, dcyc, ccnt, dcnt, n, both;
    logic [9:0] seq;

    ifa.cpu_req = 0; ifa.cpu_we = 0; ifa.cpu_adr = 0; ifa.cpu_wd = 0;
    ifa.dma_req = 0; ifa.dma_we = 0; ifa.dma_adr = 0; ifa.dma_wd = 0;
    ifb.cpu_req = 0; ifb.cpu_we = 0; ifb.cpu_adr = 0; ifb.cpu_wd = 0;
    ifb.dma_req = 0; ifb.dma_we = 0; ifb.dma_adr = 0; ifb.dma_wd = 0;
    repeat (2) step();
    mem_init = 0;

    chk("rst_busy",    32'(ifa.busy),    32'd0);
    chk("rst_mem_en",  32'(ifa.mem_en),  32'd0);
    chk("rst_mem_we",  32'(ifa.mem_we),  32'd0);
    chk("rst_cpu_ack", 32'(ifa.cpu_ack), 32'd0);
    chk("rst_dma_ack", 32'(ifa.dma_ack), 32'd0);
    chk("rst_owner",   32'(ifa.owner),   32'd0);
    chk("rst_rdata",   ifa.cpu_rd,       32'd0);
    chk("rst_mem_adr", ifa.mem_adr,      32'd0);
    reset = 0;
    step();

    // CPU read of 0x10, LAT=2; address changed after grant must not matter
    ifa.cpu_req = 1; ifa.cpu_we = 0; ifa.cpu_adr = 32'h10; ifa.cpu_wd = 32'h5555_5555;
    step();
    ifa.cpu_adr = 32'h44;
    chk("rd_c1_mem_en",  32'(ifa.mem_en), 32'd1);
    chk("rd_c1_mem_we",  32'(ifa.mem_we), 32'd0);
    chk("rd_c1_mem_adr", ifa.mem_adr,     32'h10);
    chk("rd_c1_busy",    32'(ifa.busy),   32'd1);
    step();
    chk("rd_c2_mem_en",  32'(ifa.mem_en),  32'd0);
    chk("rd_c2_ack",     32'(ifa.cpu_ack), 32'd0);
    step();
    chk("rd_c3_ack",     32'(ifa.cpu_ack), 32'd0);
    step();
    chk("rd_c4_ack",     32'(ifa.cpu_ack), 32'd1);
    chk("rd_c4_rd",      ifa.cpu_rd,       32'hDEAD_BEEF);
    chk("rd_c4_dma_ack", 32'(ifa.dma_ack), 32'd0);
    ifa.cpu_req = 0;
    step();
    chk("rd_c5_ack",  32'(ifa.cpu_ack), 32'd0);
    chk("rd_c5_busy", 32'(ifa.busy),    32'd0);

    // DMA write 0x20 <- 0x12345678
    ifa.dma_req = 1; ifa.dma_we = 1; ifa.dma_adr = 32'h20; ifa.dma_wd = 32'h1234_5678;
    step();
    ifa.dma_wd = 32'h0;
    chk("dw_c1_mem_en",  32'(ifa.mem_en), 32'd1);
    chk("dw_c1_mem_we",  32'(ifa.mem_we), 32'd1);
    chk("dw_c1_mem_adr", ifa.mem_adr,     32'h20);
    chk("dw_c1_mem_wd",  ifa.mem_wd,      32'h1234_5678);
    chk("dw_c1_owner",   32'(ifa.owner),  32'd1);
    step();
    chk("dw_c2_dma_ack", 32'(ifa.dma_ack), 32'd1);
    chk("dw_c2_cpu_ack", 32'(ifa.cpu_ack), 32'd0);
    chk("dw_c2_dma_rd",  ifa.dma_rd,       32'hDEAD_BEEF);
    ifa.dma_req = 0;
    step();
    chk("dw_c3_mem_we",  32'(ifa.mem_we),  32'd0);

    // DMA read back of the written word
    ifa.dma_req = 1; ifa.dma_we = 0; ifa.dma_adr = 32'h20;
    wait_ack(0, 1, 12, cyc);
    chk("dr_ack_cycle", 32'(cyc), 32'd4);
    chk("dr_rd", ifa.dma_rd, 32'h1234_5678);
    ifa.dma_req = 0;
    step();

    // Simultaneous write requests: CPU first, DMA after one IDLE cycle
    ifa.cpu_req = 1; ifa.cpu_we = 1; ifa.cpu_adr = 32'h30; ifa.cpu_wd = 32'hAAAA_AAAA;
    ifa.dma_req = 1; ifa.dma_we = 1; ifa.dma_adr = 32'h34; ifa.dma_wd = 32'hBBBB_BBBB;
    ccyc = -1; dcyc = -1; ccnt = 0; dcnt = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (ifa.cpu_ack === 1'b1) begin ccnt++; ccyc = k; ifa.cpu_req = 0; end
      if (ifa.dma_ack === 1'b1) begin dcnt++; dcyc = k; ifa.dma_req = 0; end
    end
    chk("sim_cpu_cycle", 32'(ccyc), 32'd2);
    chk("sim_dma_cycle", 32'(dcyc), 32'd5);
    chk("sim_cpu_count", 32'(ccnt), 32'd1);
    chk("sim_dma_count", 32'(dcnt), 32'd1);

    // Both held: four CPU grants then one DMA, repeating
    ifa.cpu_req = 1; ifa.dma_req = 1;
    n = 0; both = 0; seq = '0;
    for (int k = 1; k <= 40 && n < 10; k++) begin
      step();
      if (ifa.cpu_ack === 1'b1 && ifa.dma_ack === 1'b1) both++;
      if (ifa.cpu_ack === 1'b1 || ifa.dma_ack === 1'b1) begin
        seq[n] = ifa.dma_ack;
        n++;
      end
    end
    ifa.cpu_req = 0; ifa.dma_req = 0;
    chk("streak_grants", 32'(n),    32'd10);
    chk("streak_order",  32'(seq),  32'h210);
    chk("streak_double", 32'(both), 32'd0);
    repeat (2) step();

    // Reset in the middle of a CPU read wait
    ifa.cpu_req = 1; ifa.cpu_we = 0; ifa.cpu_adr = 32'h10;
    step();
    step();
    reset = 1;
    #1;
    chk("mid_rst_mem_en",  32'(ifa.mem_en),  32'd0);
    chk("mid_rst_busy",    32'(ifa.busy),    32'd0);
    chk("mid_rst_cpu_ack", 32'(ifa.cpu_ack), 32'd0);
    chk("mid_rst_rdata",   ifa.cpu_rd,       32'd0);
    chk("mid_rst_mem_adr", ifa.mem_adr,      32'd0);
    step();
    chk("mid_rst_hold_ack", 32'(ifa.cpu_ack), 32'd0);
    reset = 0;
    wait_ack(0, 0, 12, cyc);
    chk("post_rst_cycle", 32'(cyc), 32'd4);
    chk("post_rst_rd", ifa.cpu_rd, 32'hDEAD_BEEF);
    ifa.cpu_req = 0;
    step();

    // LAT=1 build: CPU read acks at cycle 3
    ifb.cpu_req = 1; ifb.cpu_we = 0; ifb.cpu_adr = 32'h10;
    step();
    chk("l1_c1_mem_en", 32'(ifb.mem_en), 32'd1);
    step();
    chk("l1_c2_ack",  32'(ifb.cpu_ack), 32'd0);
    chk("l1_c2_busy", 32'(ifb.busy),    32'd1);
    step();
    chk("l1_c3_ack", 32'(ifb.cpu_ack), 32'd1);
    chk("l1_c3_rd",  ifb.cpu_rd,       32'hCAFE_F00D);
    ifb.cpu_req = 0;
    step();

    // CPU writes with DMA idle leave the streak at zero, so CPU still wins the next tie
    for (int i = 0; i < 4; i++) begin
      ifb.cpu_req = 1; ifb.cpu_we = 1; ifb.cpu_adr = 32'h40 + 32'(4 * i); ifb.cpu_wd = 32'(i);
      wait_ack(1, 0, 8, cyc);
      chk("l1_wr_cycle", 32'(cyc), 32'd2);
      ifb.cpu_req = 0;
      step();
    end
    ifb.cpu_req = 1; ifb.dma_req = 1; ifb.dma_we = 1; ifb.dma_adr = 32'h50;
    cyc = -1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (ifb.cpu_ack === 1'b1 || ifb.dma_ack === 1'b1) begin
        cyc = k;
        break;
      end
    end
    chk("l1_tie_cycle",   32'(cyc),         32'd2);
    chk("l1_tie_cpu_ack", 32'(ifb.cpu_ack), 32'd1);
    chk("l1_tie_dma_ack", 32'(ifb.dma_ack), 32'd0);
    ifb.cpu_req = 0;
    wait_ack(1, 1, 8, cyc);
    chk("l1_dma_cycle", 32'(cyc), 32'd3);
    ifb.dma_req = 0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
